// File: rtl/mul_collect_pkg.sv
// Shared definitions for the multiplier result collector.
package mul_collect_pkg;

    // Outcome of comparing the pipeline's ret_valid against the expected-return tap.
    typedef enum logic [1:0] {
        RET_NONE = 2'd0,   // nothing expected, nothing arrived
        RET_OK   = 2'd1,   // expected result arrived
        RET_SPUR = 2'd2,   // result arrived that nobody issued
        RET_MISS = 2'd3    // issued result never came back
    } ret_kind_e;

    function automatic ret_kind_e classify_ret(input logic i_got, input logic i_exp);
        ret_kind_e v_kind;
        case ({i_got, i_exp})
            2'b11:   v_kind = RET_OK;
            2'b10:   v_kind = RET_SPUR;
            2'b01:   v_kind = RET_MISS;
            default: v_kind = RET_NONE;
        endcase
        return v_kind;
    endfunction

endpackage

// File: rtl/mul_collect_fifo.sv
// Circular result buffer with extended pointers (MSB distinguishes full from empty).
module mul_collect_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rd_data
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_wr;
    logic             w_do_rd;

    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign full    = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
    assign w_do_wr = wr_en && !full;
    assign w_do_rd = rd_en && !empty;
    // Head is read straight from the storage array, so ret_data never reaches rd_data in one cycle.
    assign rd_data = r_mem[r_rd_ptr[AW-1:0]];

    // Pointer advance; the power-of-two depth makes the natural overflow the wrap.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_do_wr) r_mem[r_wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/mul_collect.sv
// Credit-based collector for a fixed-latency, non-stallable multiplier.
// Every issue reserves a FIFO slot up front, so returning results always have room.
module mul_collect
    import mul_collect_pkg::*;
#(
    parameter int LAT   = 4,
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       issue,
    input  logic                       ret_valid,
    input  logic [WIDTH-1:0]           ret_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       err
);
    localparam int             CW      = $clog2(DEPTH+1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_nxt;
    logic [LAT-1:0] r_exp;
    logic           r_err;
    ret_kind_e      w_ret_kind;
    logic           w_full;
    logic           w_empty;
    logic           w_pop;
    logic           w_wr;
    logic           w_err_set;

    assign in_ready   = (r_cnt < DEPTH_C);
    assign issue      = in_valid && in_ready;
    assign w_ret_kind = classify_ret(ret_valid, r_exp[LAT-1]);
    assign w_pop      = out_ready && !w_empty;
    assign w_wr       = (w_ret_kind == RET_OK) && !w_full;
    assign w_err_set  = (w_ret_kind == RET_SPUR) || (w_ret_kind == RET_MISS) ||
                        ((w_ret_kind == RET_OK) && w_full);
    assign out_valid  = !w_empty;
    assign level      = r_cnt;
    assign err        = r_err;

    // Credit arithmetic: issue takes one, pop or a missing return gives one back.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (issue)                     w_cnt_nxt = w_cnt_nxt + 1'b1;
        if (w_pop)                     w_cnt_nxt = w_cnt_nxt - 1'b1;
        if (w_ret_kind == RET_MISS)    w_cnt_nxt = w_cnt_nxt - 1'b1;
    end

    // Credit counter and sticky error flag.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (w_err_set) r_err <= 1'b1;
        end
    end

    // Expected-return shadow of the multiplier pipe; the tail lines up with ret_valid.
    generate
        if (LAT == 1) begin : g_exp_1
            always_ff @(posedge clk or negedge reset_l) begin
                if (!reset_l) r_exp <= '0;
                else          r_exp <= issue;
            end
        end else begin : g_exp_n
            always_ff @(posedge clk or negedge reset_l) begin
                if (!reset_l) r_exp <= '0;
                else          r_exp <= {r_exp[LAT-2:0], issue};
            end
        end
    endgenerate

    mul_collect_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_l (reset_l),
        .wr_en   (w_wr),
        .wr_data (ret_data),
        .rd_en   (out_ready),
        .full    (w_full),
        .empty   (w_empty),
        .rd_data (out_data)
    );

endmodule

// File: tb/tb_mul_collect.sv
// Directed bench for mul_collect with a local fixed-delay pipe model and an ordering scoreboard.
module tb_mul_collect;
    localparam int LAT   = 4;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             reset_l = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic             issue;
    logic             ret_valid;
    logic [WIDTH-1:0] ret_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic [LW-1:0]    level;
    logic             err;

    logic [WIDTH-1:0] op_data = '0;
    logic             spur = 1'b0;
    logic             suppress = 1'b0;

    logic             pv [LAT];
    logic [WIDTH-1:0] pd [LAT];

    logic [WIDTH-1:0] sb_q [$];
    int checks = 0;
    int errors = 0;
    int n_iss  = 0;
    int n_pop  = 0;
    int cyc    = 0;
    int first_pop = -1;
    int last_pop  = -1;

    always #5 clk = ~clk;

    mul_collect #(.LAT(LAT), .WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_l   (reset_l),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .issue     (issue),
        .ret_valid (ret_valid),
        .ret_data  (ret_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level),
        .err       (err)
    );

    // Multiplier pipe model (not reset, like the real non-stallable pipe) and scoreboard push.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (issue) begin
            sb_q.push_back(op_data);
            n_iss = n_iss + 1;
        end
        pv[0] <= issue;
        pd[0] <= op_data;
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end

    assign ret_valid = (pv[LAT-1] && !suppress) || spur;
    assign ret_data  = spur ? 32'hDEAD_BEEF : pd[LAT-1];

    // Output monitor: every accepted head must match the oldest issued operand.
    always @(negedge clk) begin
        if (reset_l && out_valid && out_ready) begin
            n_pop = n_pop + 1;
            if (first_pop < 0) first_pop = cyc;
            last_pop = cyc;
            checks = checks + 1;
            if (sb_q.size() == 0) begin
                errors = errors + 1;
                $display("FAIL pop_unexpected: got %h, scoreboard empty", out_data);
            end else begin
                logic [WIDTH-1:0] v_exp;
                v_exp = sb_q.pop_front();
                if (out_data !== v_exp) begin
                    errors = errors + 1;
                    $display("FAIL pop_data: got %h, want %h", out_data, v_exp);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks = checks + 1;
        if (act !== req) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        out_ready = 1'b0;
        spur = 1'b0;
        suppress = 1'b0;
        reset_l = 1'b0;
        repeat (LAT + 2) step();
        sb_q.delete();
        reset_l = 1'b1;
        step();
        n_iss = 0;
        n_pop = 0;
        first_pop = -1;
        last_pop = -1;
    endtask

    task automatic drain(input string name);
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (out_valid || sb_q.size() != 0); i++) step();
        chk({name, "_drain_valid"}, {31'd0, out_valid}, 32'd0);
        chk({name, "_drain_sb"}, sb_q.size(), 32'd0);
        out_ready = 1'b0;
    endtask

    initial begin
        int drops;
        logic [6:0] pat;

        // Reset values
        reset_l = 1'b0;
        repeat (LAT + 2) step();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_level", {28'd0, level}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        in_valid = 1'b1;
        #1;
        chk("rst_issue_follows", {31'd0, issue}, 32'd1);
        in_valid = 1'b0;
        #1;
        chk("rst_issue_low", {31'd0, issue}, 32'd0);
        do_reset();

        // Single issue, latency LAT+1
        op_data = 32'h1234;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("single_level_c1", {28'd0, level}, 32'd1);
        repeat (3) step();
        chk("single_not_early", {31'd0, out_valid}, 32'd0);
        chk("single_level_c4", {28'd0, level}, 32'd1);
        step();
        chk("single_valid_c5", {31'd0, out_valid}, 32'd1);
        chk("single_data_c5", out_data, 32'h1234);
        chk("single_level_c5", {28'd0, level}, 32'd1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("single_level_after_pop", {28'd0, level}, 32'd0);
        chk("single_empty_after_pop", {31'd0, out_valid}, 32'd0);

        // Fill to DEPTH with downstream stalled
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            op_data = 32'h2000 + i;
            step();
        end
        in_valid = 1'b0;
        chk("fill_issues", n_iss, DEPTH);
        chk("fill_in_ready", {31'd0, in_ready}, 32'd0);
        chk("fill_level", {28'd0, level}, DEPTH);
        out_ready = 1'b1;
        step();
        chk("fill_ready_after_pop", {31'd0, in_ready}, 32'd1);
        drain("fill");
        chk("fill_pops", n_pop, DEPTH);

        // 100 back-to-back with downstream always ready
        do_reset();
        out_ready = 1'b1;
        drops = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 100; i++) begin
            op_data = 32'h3000 + i;
            if (!in_ready) drops++;
            step();
        end
        in_valid = 1'b0;
        drain("b2b");
        chk("b2b_ready_drops", drops, 32'd0);
        chk("b2b_pops", n_pop, 32'd100);
        chk("b2b_consecutive", last_pop - first_pop, 32'd99);
        chk("b2b_err", {31'd0, err}, 32'd0);

        // Spurious return with nothing in flight
        do_reset();
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_err", {31'd0, err}, 32'd1);
        chk("spur_out_valid", {31'd0, out_valid}, 32'd0);
        chk("spur_level", {28'd0, level}, 32'd0);

        // Suppressed return releases its credit
        do_reset();
        op_data = 32'h55;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        suppress = 1'b1;
        sb_q.delete();
        chk("miss_level_before", {28'd0, level}, 32'd1);
        repeat (LAT + 1) step();
        suppress = 1'b0;
        chk("miss_err", {31'd0, err}, 32'd1);
        chk("miss_level_after", {28'd0, level}, 32'd0);
        chk("miss_out_valid", {31'd0, out_valid}, 32'd0);

        // Simultaneous issue and pop at level 7
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            op_data = 32'h4000 + i;
            step();
        end
        in_valid = 1'b0;
        repeat (LAT + 2) step();
        chk("l7_level", {28'd0, level}, 32'd7);
        op_data = 32'h4007;
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("l7_level_hold", {28'd0, level}, 32'd7);
        drain("l7");
        chk("l7_level_end", {28'd0, level}, 32'd0);

        // Wrap-around over 3*DEPTH items with a fixed stall pattern
        do_reset();
        pat = 7'b1011001;
        for (int g = 0; g < 500 && n_iss < 3 * DEPTH; g++) begin
            in_valid = 1'b1;
            out_ready = pat[g % 7];
            op_data = 32'h5000 + g;
            step();
        end
        in_valid = 1'b0;
        drain("wrap");
        chk("wrap_issues", n_iss, 3 * DEPTH);
        chk("wrap_pops", n_pop, 3 * DEPTH);
        chk("wrap_err", {31'd0, err}, 32'd0);

        // Reset with 3 stored and 2 in flight, then late returns
        do_reset();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            op_data = 32'h6000 + i;
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        chk("mid_level_before", {28'd0, level}, 32'd5);
        reset_l = 1'b0;
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_level", {28'd0, level}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid_rst_err", {31'd0, err}, 32'd0);
        sb_q.delete();
        #1;
        reset_l = 1'b1;
        step();
        chk("mid_late_err", {31'd0, err}, 32'd1);
        chk("mid_late_out_valid", {31'd0, out_valid}, 32'd0);
        step();
        chk("mid_late_level", {28'd0, level}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
